// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - burst-based line-select sequencer driving a two-way output demultiplexer
module demux_dispatcher #(
    parameter int WIDTH = 2,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             c_valid,
    input  logic             c_ready,
    input  logic             force_en,
    input  logic             force_sel,
    output logic             sel,
    output logic [7:0]       burst_cnt
);

    localparam logic [7:0] LP_LAST = 8'(BURST - 1);

    logic             r_sel;
    logic [7:0]       r_burst_cnt;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_valid;
    logic [WIDTH-1:0] r_c_data;
    logic             r_c_valid;

    logic w_sel_valid;
    logic w_sel_ready;
    logic w_xfer;
    logic w_wrap;
    logic w_wr_b;
    logic w_wr_c;

    // Only the selected line's holding register gates acceptance; the other line drains on its own
    assign w_sel_valid = r_sel ? r_c_valid : r_b_valid;
    assign w_sel_ready = r_sel ? c_ready   : b_ready;
    assign a_ready     = rst_n && (!w_sel_valid || w_sel_ready);

    assign w_xfer = a_valid && a_ready;
    assign w_wrap = w_xfer && (r_burst_cnt == LP_LAST);
    assign w_wr_b = w_xfer && !r_sel;
    assign w_wr_c = w_xfer &&  r_sel;

    // Select and burst counter: select may only move at a burst wrap or at an idle burst boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= 1'b0;
            r_burst_cnt <= 8'd0;
        end else if (w_xfer) begin
            if (w_wrap) begin
                r_burst_cnt <= 8'd0;
                r_sel       <= force_en ? force_sel : ~r_sel;
            end else begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
        end else if ((r_burst_cnt == 8'd0) && force_en && (force_sel != r_sel)) begin
            r_sel <= force_sel;
        end
    end

    // Line B holding register: a write in the same cycle as a drain keeps it full with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_data  <= '0;
            r_b_valid <= 1'b0;
        end else if (w_wr_b) begin
            r_b_data  <= a_data;
            r_b_valid <= 1'b1;
        end else if (b_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Line C holding register, same rules as line B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_data  <= '0;
            r_c_valid <= 1'b0;
        end else if (w_wr_c) begin
            r_c_data  <= a_data;
            r_c_valid <= 1'b1;
        end else if (c_ready) begin
            r_c_valid <= 1'b0;
        end
    end

    // Idle lines present zero data so the unselected line has a defined value
    assign b_data    = r_b_valid ? r_b_data : '0;
    assign b_valid   = r_b_valid;
    assign c_data    = r_c_valid ? r_c_data : '0;
    assign c_valid   = r_c_valid;
    assign sel       = r_sel;
    assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - scoreboard bench for demux_dispatcher (BURST=4 and BURST=1 instances)
module tb_demux_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [1:0] b_data;
    logic       b_valid;
    logic       b_ready = 1'b1;
    logic [1:0] c_data;
    logic       c_valid;
    logic       c_ready = 1'b1;
    logic       force_en = 1'b0;
    logic       force_sel = 1'b0;
    logic       sel;
    logic [7:0] burst_cnt;

    logic [1:0] a1_data = '0;
    logic       a1_valid = 1'b0;
    logic       a1_ready;
    logic [1:0] b1_data;
    logic       b1_valid;
    logic [1:0] c1_data;
    logic       c1_valid;
    logic       sel1;
    logic [7:0] burst_cnt1;

    int checks = 0;
    int errors = 0;

    logic [1:0] qb[$];
    logic [1:0] qc[$];
    logic [1:0] qb1[$];
    logic [1:0] qc1[$];
    logic [1:0] e0;
    logic [1:0] e1;

    always #5 clk = ~clk;

    demux_dispatcher #(.WIDTH(2), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
        .force_en(force_en), .force_sel(force_sel),
        .sel(sel), .burst_cnt(burst_cnt)
    );

    demux_dispatcher #(.WIDTH(2), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_data(a1_data), .a_valid(a1_valid), .a_ready(a1_ready),
        .b_data(b1_data), .b_valid(b1_valid), .b_ready(1'b1),
        .c_data(c1_data), .c_valid(c1_valid), .c_ready(1'b1),
        .force_en(1'b0), .force_sel(1'b0),
        .sel(sel1), .burst_cnt(burst_cnt1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one word; push its expected line entry once the DUT accepts it
    task automatic send(input logic [1:0] d, input bit to_c, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        a_data  = d;
        a_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %0d got no a_ready expected a_ready=1", d);
        end else if (to_c) qc.push_back(d);
        else qb.push_back(d);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Monitor for the BURST=4 instance: pops on each consumed word, checks idle masking
    always @(negedge clk) begin
        if (b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected got %0d expected no word", b_data);
            end else begin
                e0 = qb.pop_front();
                chk("b_data", b_data, e0);
            end
        end
        if (c_valid && c_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected got %0d expected no word", c_data);
            end else begin
                e0 = qc.pop_front();
                chk("c_data", c_data, e0);
            end
        end
        if (!b_valid) chk("b_mask", b_data, 0);
        if (!c_valid) chk("c_mask", c_data, 0);
    end

    // Monitor for the BURST=1 instance (both consumers always ready)
    always @(negedge clk) begin
        if (b1_valid) begin
            if (qb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL b1_unexpected got %0d expected no word", b1_data);
            end else begin
                e1 = qb1.pop_front();
                chk("b1_data", b1_data, e1);
            end
        end
        if (c1_valid) begin
            if (qc1.size() == 0) begin
                checks++; errors++;
                $display("FAIL c1_unexpected got %0d expected no word", c1_data);
            end else begin
                e1 = qc1.pop_front();
                chk("c1_data", c1_data, e1);
            end
        end
        if (!c1_valid) chk("c1_mask", c1_data, 0);
    end

    initial begin
        int st;
        // Reset state
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_c_valid", c_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_a_ready", a_ready, 1);

        // Round-robin: 4 words on B then 4 on C, no stalls
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            send(2'(i % 4), (i >= 4), st);
            chk("rr_stall", st, 0);
            if (i == 3) chk("rr_sel_after4", sel, 1);
        end
        chk("rr_sel_after8", sel, 0);
        chk("rr_cnt_after8", burst_cnt, 0);

        // Backpressure on B after the first word
        b_ready = 1'b0;
        send(2'd1, 1'b0, st);
        a_data  = 2'd2;
        a_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_valid", b_valid, 1);
            chk("bp_b_data", b_data, 1);
            chk("bp_cnt", burst_cnt, 1);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_ready = 1'b1;
        send(2'd2, 1'b0, st); chk("bp_resume_stall", st, 0);
        send(2'd3, 1'b0, st); chk("bp_resume_stall", st, 0);
        send(2'd0, 1'b0, st); chk("bp_resume_stall", st, 0);
        chk("bp_sel", sel, 1);

        // Forced mode asserted mid-burst on B
        for (int i = 0; i < 4; i++) send(2'(i), 1'b1, st);
        chk("f_sel_b", sel, 0);
        send(2'd1, 1'b0, st);
        send(2'd2, 1'b0, st);
        chk("f_cnt2", burst_cnt, 2);
        force_en  = 1'b1;
        force_sel = 1'b1;
        @(negedge clk);
        chk("f_midburst_sel", sel, 0);
        @(posedge clk); #1;
        send(2'd3, 1'b0, st);
        send(2'd0, 1'b0, st);
        chk("f_sel_c", sel, 1);
        for (int i = 0; i < 8; i++) send(2'((i + 1) % 4), 1'b1, st);
        chk("f_sel_stays", sel, 1);
        repeat (2) @(posedge clk);
        #3;

        // Idle boundary force after reset
        rst_n = 1'b0;
        #1;
        chk("r2_sel", sel, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_sel_before", sel, 0);
        chk("idle_a_ready", a_ready, 1);
        @(posedge clk); #1;
        chk("idle_sel_after", sel, 1);
        force_en = 1'b0;
        send(2'd1, 1'b1, st);
        send(2'd2, 1'b1, st);
        send(2'd3, 1'b1, st);
        c_ready = 1'b0;
        chk("ar_cnt3", burst_cnt, 3);
        chk("ar_c_held", c_valid, 1);

        // Async reset with a word held on C
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_c_valid", c_valid, 0);
        chk("ar_c_data", c_data, 0);
        chk("ar_a_ready", a_ready, 0);
        qc.delete();
        @(posedge clk); #1;
        rst_n   = 1'b1;
        c_ready = 1'b1;
        @(negedge clk);
        chk("ar_rel_sel", sel, 0);
        chk("ar_rel_cnt", burst_cnt, 0);
        chk("ar_rel_a_ready", a_ready, 1);

        // BURST=1 instance: alternating lines every word
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            a1_data  = 2'(i % 4);
            a1_valid = 1'b1;
            @(negedge clk);
            chk("b1_a_ready", a1_ready, 1);
            if (i % 2 == 1) qb1.push_back(2'(i % 4));
            else qc1.push_back(2'(i % 4));
            @(posedge clk); #1;
        end
        a1_valid = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);
        chk("qb1_empty", qb1.size(), 0);
        chk("qc1_empty", qc1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
